// File: rtl/riscv_pkg.sv
// Shared RV64I+Zba decode types: ALU op codes, operand-A selects, opcode/funct constants
// and the decoded bundle carried from decode to execute.
package riscv_pkg;

  localparam int unsigned RV_XLEN = 64;

  typedef enum logic [4:0] {
    ALU_ADD       = 5'd0,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_ADDW,
    ALU_SUBW,
    ALU_SLLW,
    ALU_SRLW,
    ALU_SRAW,
    ALU_SH1ADD,
    ALU_SH2ADD,
    ALU_SH3ADD,
    ALU_SH1ADD_UW,
    ALU_SH2ADD_UW,
    ALU_SH3ADD_UW,
    ALU_ADD_UW,
    ALU_SLLI_UW
  } alu_op_t;

  typedef enum logic [1:0] {
    OPA_RS1  = 2'd0,
    OPA_PC   = 2'd1,
    OPA_ZERO = 2'd2
  } opa_sel_t;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;

  localparam logic [6:0] F7_BASE      = 7'b0000000;
  localparam logic [6:0] F7_ALT       = 7'b0100000;
  localparam logic [6:0] F7_ZBA_SHADD = 7'b0010000;
  localparam logic [6:0] F7_ZBA_ADDUW = 7'b0000100;
  localparam logic [5:0] F6_BASE      = 6'b000000;
  localparam logic [5:0] F6_ALT       = 6'b010000;
  localparam logic [5:0] F6_ZBA_SLLIUW = 6'b000010;

  typedef struct packed {
    alu_op_t              alu_op;
    opa_sel_t             opa_sel;
    logic                 opb_imm;
    logic [RV_XLEN-1:0]   imm;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [4:0]           rd;
    logic                 reg_we;
    logic                 illegal;
  } dec_bundle_t;

  localparam dec_bundle_t DEC_RESET = '{
    alu_op: ALU_ADD, opa_sel: OPA_RS1, opb_imm: 1'b0, imm: '0,
    rs1: '0, rs2: '0, rd: '0, reg_we: 1'b0, illegal: 1'b0
  };

  function automatic logic [RV_XLEN-1:0] sext12(input logic [11:0] v);
    return {{(RV_XLEN-12){v[11]}}, v};
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV64I instruction -> ALU control bundle.
// Define RV_ZBA_EN to also decode the Zba sh*add / *.uw / slli.uw encodings.
module instr_decoder
  import riscv_pkg::*;
(
  input  logic [31:0]  instr,
  output dec_bundle_t  dec
);

  logic [6:0]         opc;
  logic [2:0]         f3;
  logic [6:0]         f7;
  logic [5:0]         f6;
  logic               legal;
  alu_op_t            alu;
  opa_sel_t           opa;
  logic               opb;
  logic [RV_XLEN-1:0] imm;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];
  assign f6  = instr[31:26];

  always_comb begin
    alu   = ALU_ADD;
    opa   = OPA_RS1;
    opb   = 1'b0;
    imm   = '0;
    legal = 1'b1;
    case (opc)
      OPC_OP: begin
        case ({f7, f3})
          {F7_BASE, 3'b000}: alu = ALU_ADD;
          {F7_ALT,  3'b000}: alu = ALU_SUB;
          {F7_BASE, 3'b001}: alu = ALU_SLL;
          {F7_BASE, 3'b010}: alu = ALU_SLT;
          {F7_BASE, 3'b011}: alu = ALU_SLTU;
          {F7_BASE, 3'b100}: alu = ALU_XOR;
          {F7_BASE, 3'b101}: alu = ALU_SRL;
          {F7_ALT,  3'b101}: alu = ALU_SRA;
          {F7_BASE, 3'b110}: alu = ALU_OR;
          {F7_BASE, 3'b111}: alu = ALU_AND;
`ifdef RV_ZBA_EN
          {F7_ZBA_SHADD, 3'b010}: alu = ALU_SH1ADD;
          {F7_ZBA_SHADD, 3'b100}: alu = ALU_SH2ADD;
          {F7_ZBA_SHADD, 3'b110}: alu = ALU_SH3ADD;
`endif
          default: legal = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        opb = 1'b1;
        imm = sext12(instr[31:20]);
        case (f3)
          3'b000: alu = ALU_ADD;
          3'b010: alu = ALU_SLT;
          3'b011: alu = ALU_SLTU;
          3'b100: alu = ALU_XOR;
          3'b110: alu = ALU_OR;
          3'b111: alu = ALU_AND;
          3'b001: begin
            alu   = ALU_SLL;
            imm   = {{(RV_XLEN-6){1'b0}}, instr[25:20]};
            legal = (f6 == F6_BASE);
          end
          default: begin
            imm = {{(RV_XLEN-6){1'b0}}, instr[25:20]};
            if (f6 == F6_BASE)     alu = ALU_SRL;
            else if (f6 == F6_ALT) alu = ALU_SRA;
            else                   legal = 1'b0;
          end
        endcase
      end
      OPC_OP_IMM_32: begin
        opb = 1'b1;
        imm = sext12(instr[31:20]);
        case (f3)
          3'b000: alu = ALU_ADDW;
          3'b001: begin
            imm = {{(RV_XLEN-5){1'b0}}, instr[24:20]};
            // slli.uw keeps a 6-bit shamt, so it must be matched before the instr[25] check
`ifdef RV_ZBA_EN
            if (f6 == F6_ZBA_SLLIUW) begin
              alu = ALU_SLLI_UW;
              imm = {{(RV_XLEN-6){1'b0}}, instr[25:20]};
            end else
`endif
            if (f7 == F7_BASE) alu = ALU_SLLW;
            else               legal = 1'b0;
          end
          3'b101: begin
            imm = {{(RV_XLEN-5){1'b0}}, instr[24:20]};
            if (f7 == F7_BASE)     alu = ALU_SRLW;
            else if (f7 == F7_ALT) alu = ALU_SRAW;
            else                   legal = 1'b0;
          end
          default: legal = 1'b0;
        endcase
      end
      OPC_OP_32: begin
        case ({f7, f3})
          {F7_BASE, 3'b000}: alu = ALU_ADDW;
          {F7_ALT,  3'b000}: alu = ALU_SUBW;
          {F7_BASE, 3'b001}: alu = ALU_SLLW;
          {F7_BASE, 3'b101}: alu = ALU_SRLW;
          {F7_ALT,  3'b101}: alu = ALU_SRAW;
`ifdef RV_ZBA_EN
          {F7_ZBA_SHADD, 3'b010}: alu = ALU_SH1ADD_UW;
          {F7_ZBA_SHADD, 3'b100}: alu = ALU_SH2ADD_UW;
          {F7_ZBA_SHADD, 3'b110}: alu = ALU_SH3ADD_UW;
          {F7_ZBA_ADDUW, 3'b000}: alu = ALU_ADD_UW;
`endif
          default: legal = 1'b0;
        endcase
      end
      OPC_LUI, OPC_AUIPC: begin
        opa = (opc == OPC_LUI) ? OPA_ZERO : OPA_PC;
        opb = 1'b1;
        imm = {{(RV_XLEN-32){instr[31]}}, instr[31:12], 12'b0};
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      alu = ALU_ADD;
      opa = OPA_RS1;
      opb = 1'b0;
      imm = '0;
    end
  end

  assign dec = '{
    alu_op:  alu,
    opa_sel: opa,
    opb_imm: opb,
    imm:     imm,
    rs1:     instr[19:15],
    rs2:     instr[24:20],
    rd:      instr[11:7],
    reg_we:  legal && (instr[11:7] != 5'd0),
    illegal: !legal
  };

endmodule

// File: rtl/decode_stage.sv
// Pipelined RV64I(+Zba when RV_ZBA_EN is defined) decode stage: one registered output
// slot with valid/ready handshake and flush.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output alu_op_t         out_alu_op,
  output opa_sel_t        out_opa_sel,
  output logic            out_opb_imm,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_reg_we,
  output logic            out_illegal
);

  dec_bundle_t     dec;
  dec_bundle_t     bundle_d, bundle_q;
  logic            valid_d, valid_q;
  logic [XLEN-1:0] pc_d, pc_q;
  logic            push;

  instr_decoder u_dec (
    .instr (in_instr),
    .dec   (dec)
  );

  assign in_ready = !valid_q || out_ready;
  assign push     = in_valid && in_ready && !flush;

  always_comb begin
    valid_d  = valid_q;
    bundle_d = bundle_q;
    pc_d     = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (push) begin
      valid_d  = 1'b1;
      bundle_d = dec;
      pc_d     = in_pc;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      bundle_q <= DEC_RESET;
      pc_q     <= '0;
    end else begin
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
      pc_q     <= pc_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_pc      = pc_q;
  assign out_alu_op  = bundle_q.alu_op;
  assign out_opa_sel = bundle_q.opa_sel;
  assign out_opb_imm = bundle_q.opb_imm;
  assign out_imm     = bundle_q.imm;
  assign out_rs1     = bundle_q.rs1;
  assign out_rs2     = bundle_q.rs2;
  assign out_rd      = bundle_q.rd;
  assign out_reg_we  = bundle_q.reg_we;
  assign out_illegal = bundle_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed instructions with hand-computed bundles,
// backpressure, flush and async reset. Expectations follow RV_ZBA_EN when defined.
module tb_decode_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  alu_op_t     out_alu_op;
  opa_sel_t    out_opa_sel;
  logic        out_opb_imm;
  logic [63:0] out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic        out_reg_we;
  logic        out_illegal;

  decode_stage #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_alu_op(out_alu_op), .out_opa_sel(out_opa_sel), .out_opb_imm(out_opb_imm),
    .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_reg_we(out_reg_we), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    alu_op_t     alu;
    opa_sel_t    opa;
    logic        opb;
    logic [63:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic        we, ill;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011, OP32 = 7'b0111011, OPI32 = 7'b0011011;

  function automatic exp_t mk(input logic [63:0] pc, input alu_op_t alu, input opa_sel_t opa,
                              input logic opb, input logic [63:0] imm, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [4:0] rd, input logic we,
                              input logic ill);
    exp_t e;
    e.pc = pc; e.alu = alu; e.opa = opa; e.opb = opb; e.imm = imm;
    e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.we = we; e.ill = ill;
    return e;
  endfunction

  function automatic exp_t mk_ill(input logic [63:0] pc, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic [4:0] rd);
    return mk(pc, ALU_ADD, OPA_RS1, 1'b0, 64'd0, rs1, rs2, rd, 1'b0, 1'b1);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_bundle: got pc=%h op=%0d with nothing expected", out_pc, out_alu_op);
      end else begin
        mon_e = sb.pop_front();
        if ({out_pc, out_alu_op, out_opa_sel, out_opb_imm, out_imm, out_rs1, out_rs2, out_rd,
             out_reg_we, out_illegal} !==
            {mon_e.pc, mon_e.alu, mon_e.opa, mon_e.opb, mon_e.imm, mon_e.rs1, mon_e.rs2,
             mon_e.rd, mon_e.we, mon_e.ill}) begin
          n_bad++;
          $display("FAIL bundle pc=%h: got op=%0d opa=%0d opb=%0b imm=%h rs1=%0d rs2=%0d rd=%0d we=%0b ill=%0b, expected pc=%h op=%0d opa=%0d opb=%0b imm=%h rs1=%0d rs2=%0d rd=%0d we=%0b ill=%0b",
                   mon_e.pc, out_alu_op, out_opa_sel, out_opb_imm, out_imm, out_rs1, out_rs2,
                   out_rd, out_reg_we, out_illegal, mon_e.pc, mon_e.alu, mon_e.opa, mon_e.opb,
                   mon_e.imm, mon_e.rs1, mon_e.rs2, mon_e.rd, mon_e.we, mon_e.ill);
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that took the instruction.
  task automatic send(input logic [31:0] instr, input exp_t e);
    bit hs = 1'b0;
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = e.pc;
    for (int k = 0; k < 20 && !hs; k++) begin
      @(negedge clk);
      if (in_ready) begin
        hs = 1'b1;
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!hs) begin
      n_cmp++;
      n_bad++;
      $display("FAIL handshake_timeout: pc=%h not accepted, required acceptance within 20 cycles", e.pc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t a, b, c;
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_alu_op", out_alu_op, ALU_ADD);
    check("rst_opa_sel", out_opa_sel, OPA_RS1);
    check("rst_imm", out_imm, 0);
    check("rst_reg_we", out_reg_we, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(32'hFFF30293, mk(64'h1000, ALU_ADD, OPA_RS1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 6, 31, 5, 1, 0));
    send(32'h800003B7, mk(64'h1004, ALU_ADD, OPA_ZERO, 1, 64'hFFFF_FFFF_8000_0000, 0, 0, 7, 1, 0));
    send({20'hFFFFF, 5'd3, 7'b0010111},
         mk(64'h1008, ALU_ADD, OPA_PC, 1, 64'hFFFF_FFFF_FFFF_F000, 31, 31, 3, 1, 0));
    send({7'b0000000, 5'd2, 5'd1, 3'b000, 5'd0, OP},
         mk(64'h100C, ALU_ADD, OPA_RS1, 0, 64'd0, 1, 2, 0, 0, 0));
    send({7'b0100000, 5'd12, 5'd11, 3'b000, 5'd10, OP},
         mk(64'h1010, ALU_SUB, OPA_RS1, 0, 64'd0, 11, 12, 10, 1, 0));
    send({6'b010000, 6'd63, 5'd5, 3'b101, 5'd4, OPI},
         mk(64'h1014, ALU_SRA, OPA_RS1, 1, 64'd63, 5, 31, 4, 1, 0));
    send({6'b000001, 6'd3, 5'd5, 3'b101, 5'd4, OPI}, mk_ill(64'h1018, 5, 3, 4));
    send({12'h800, 5'd2, 3'b011, 5'd1, OPI},
         mk(64'h101C, ALU_SLTU, OPA_RS1, 1, 64'hFFFF_FFFF_FFFF_F800, 2, 0, 1, 1, 0));
    send({7'b0100000, 5'd8, 5'd7, 3'b101, 5'd6, OP32},
         mk(64'h1020, ALU_SRAW, OPA_RS1, 0, 64'd0, 7, 8, 6, 1, 0));
    send({7'b0100000, 5'd31, 5'd9, 3'b101, 5'd9, OPI32},
         mk(64'h1024, ALU_SRAW, OPA_RS1, 1, 64'd31, 9, 31, 9, 1, 0));
    send(32'h0200909B, mk_ill(64'h1028, 1, 0, 1));
    send({12'h000, 5'd1, 3'b011, 5'd5, 7'b0000011}, mk_ill(64'h102C, 1, 0, 5));
`ifdef RV_ZBA_EN
    send(32'h203140B3, mk(64'h1030, ALU_SH2ADD, OPA_RS1, 0, 64'd0, 2, 3, 1, 1, 0));
    send({7'b0000100, 5'd3, 5'd2, 3'b000, 5'd1, OP32},
         mk(64'h1034, ALU_ADD_UW, OPA_RS1, 0, 64'd0, 2, 3, 1, 1, 0));
    send({6'b000010, 6'd40, 5'd2, 3'b001, 5'd1, OPI32},
         mk(64'h1038, ALU_SLLI_UW, OPA_RS1, 1, 64'd40, 2, 8, 1, 1, 0));
`else
    send(32'h203140B3, mk_ill(64'h1030, 2, 3, 1));
    send({7'b0000100, 5'd3, 5'd2, 3'b000, 5'd1, OP32}, mk_ill(64'h1034, 2, 3, 1));
    send({6'b000010, 6'd40, 5'd2, 3'b001, 5'd1, OPI32}, mk_ill(64'h1038, 2, 8, 1));
`endif
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: A held for two cycles while B waits, then B and C back to back.
    a = mk(64'h2000, ALU_ADD, OPA_RS1, 1, 64'd5, 0, 5, 1, 1, 0);
    b = mk(64'h2004, ALU_XOR, OPA_RS1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 31, 2, 1, 0);
    c = mk(64'h2008, ALU_AND, OPA_RS1, 0, 64'd0, 1, 2, 3, 1, 0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = {12'd5, 5'd0, 3'b000, 5'd1, OPI}; in_pc = a.pc;
    @(negedge clk);
    check("bp_accept_a", in_ready, 1);
    sb.push_back(a);
    @(posedge clk); #1;
    in_instr = {12'hFFF, 5'd1, 3'b100, 5'd2, OPI}; in_pc = b.pc;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("bp_in_ready_low", in_ready, 0);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_imm", out_imm, a.imm);
      check("bp_hold_pc", out_pc, a.pc);
      check("bp_hold_rd", out_rd, a.rd);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release", in_ready, 1);
    sb.push_back(b);
    @(posedge clk); #1;
    in_instr = {7'b0000000, 5'd2, 5'd1, 3'b111, 5'd3, OP}; in_pc = c.pc;
    @(negedge clk);
    check("bp_back_to_back", in_ready, 1);
    sb.push_back(c);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_drained", out_valid, 0);

    // Flush on the same cycle as an accepted push.
    @(posedge clk); #1;
    in_valid = 1'b1; flush = 1'b1; in_instr = {12'd7, 5'd0, 3'b000, 5'd4, OPI}; in_pc = 64'h3000;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_push_dropped", out_valid, 0);

    // Flush of a held bundle.
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = {12'd9, 5'd0, 3'b000, 5'd4, OPI}; in_pc = 64'h3004;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_held_loaded", out_valid, 1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("flush_held_killed", out_valid, 0);

    // Asynchronous reset while a bundle is held.
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = {12'hFFF, 5'd1, 3'b100, 5'd2, OPI}; in_pc = 64'h4000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("async_pre_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_alu_op", out_alu_op, ALU_ADD);
    check("async_rst_imm", out_imm, 0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;

    send({12'd1, 5'd3, 3'b110, 5'd3, OPI}, mk(64'h5000, ALU_OR, OPA_RS1, 1, 64'd1, 3, 1, 3, 1, 0));
    repeat (2) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
